mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage directly downstream of the execute ALU. Consumes the ALU result as an address
//  for LW/SW/LB/LBU/SB or as a pass-through value, and runs a req/ack data-memory handshake.
//  It stalls execute while an access is outstanding and delivers one writeback record per instruction.
// PARAMETERS
//  MAX_WAIT   16   cycles mem_req may stay high without mem_ack before the access is aborted (>=1)
// PORTS
//  clock          in   1   rising-edge clock
//  reset_n        in   1   asynchronous, active-low reset
//  in_valid       in   1   execute result valid this cycle
//  in_ready       out  1   stage can accept; combinational, =1 only in IDLE
//  in_insn        in   32  instruction word; opcode = in_insn[31:26]
//  in_pc          in   32  instruction PC
//  in_alu_result  in   32  ALU dataOut: byte address for memory ops, otherwise the result value
//  in_rt_data     in   32  rt register value (store data)
//  in_dest_reg    in   5   destination register number
//  in_reg_write   in   1   instruction writes a register
//  mem_req        out  1   memory request; held high until ack or timeout
//  mem_we         out  1   1 = write (SW/SB), 0 = read
//  mem_addr       out  32  word address: {addr[31:2],2'b00}
//  mem_wdata      out  32  write data
//  mem_be         out  4   byte enables, big-endian lane order
//  mem_ack        in   1   memory completes the request on this edge
//  mem_rdata      in   32  read data; valid when mem_ack=1
//  wb_valid       out  1   one-cycle pulse: writeback record valid
//  wb_data        out  32  value to write back
//  wb_dest        out  5   destination register
//  wb_reg_write   out  1   write enable; forced 0 when wb_dest==0 or on error
//  wb_pc          out  32  PC of retiring instruction
//  mem_err        out  1   one-cycle pulse with wb_valid: misaligned access or timeout
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; wait counter 0. Reset mid-access abandons it and drops mem_req at once.
//  All outputs except in_ready are registered. Accept = in_valid & in_ready at a clock edge.
//  Opcodes: LW 100011, SW 101011, LB 100000, LBU 100100, SB 101000. Any other opcode is pass-through.
//  Pass-through: at the accepting edge, wb_valid=1, wb_data=in_alu_result, other wb_* captured.
//    State stays IDLE, so back-to-back accepts give a wb pulse every cycle.
//  Misaligned LW/SW (addr[1:0]!=0): no request is issued. At the accepting edge,
//    wb_valid=1, mem_err=1, wb_reg_write=0. LB/LBU/SB are never misaligned.
//  Memory op, at the accepting edge: state goes to ACCESS; mem_req=1.
//    mem_addr, mem_we, mem_wdata and mem_be are loaded and held stable until the request ends.
//    LW/SW: mem_be=1111; mem_wdata=rt.
//    Byte ops: lane from addr[1:0]: 00->1000 [31:24], 01->0100, 10->0010, 11->0001 [7:0].
//    SB: mem_wdata = {4{rt[7:0]}}.
//  ACCESS, edge with mem_ack=1:
//    mem_req drops to 0; state goes to IDLE; wb_valid=1.
//    wb_data: LW = mem_rdata; LB = sign-extended selected byte; LBU = zero-extended selected byte; SW/SB = 0.
//    wb_reg_write=0 for stores.
//  ACCESS, no ack: the wait counter increments.
//    The MAX_WAIT-th edge without ack aborts the access: mem_req=0, IDLE, wb_valid=1, mem_err=1, wb_reg_write=0.
//  mem_ack seen while in IDLE is ignored.
//  Latency: pass-through 1 cycle. Memory op: request visible the cycle after accept.
//    Writeback follows the ack edge. Next accept is no earlier than one edge after the ack edge.
//  wb_valid and mem_err are 0 on every edge that does not set them.
//  Wait counter width $clog2(MAX_WAIT+1); it clears on entry to ACCESS.
// TESTING
//  ADDU result 0x1234, dest 5, three consecutive accepts -> three wb_valid pulses, wb_data=0x1234, wb_reg_write=1.
//  LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF:
//    mem_req high 3 cycles, mem_be=1111, in_ready=0 throughout, then wb_data=0xDEADBEEF.
//  Byte loads, rdata 0x11F02233:
//    LB addr 0x101 -> mem_be=0100, wb_data=0xFFFFFFF0.
//    LBU addr 0x101 -> wb_data=0x000000F0.
//  SB addr 0x203, rt=0xAB -> mem_be=0001, mem_wdata=0xABABABAB, mem_we=1, wb_reg_write=0.
//  LW addr 0x102 -> no mem_req, mem_err pulse, wb_reg_write=0.
//    LW with no ack -> abort after MAX_WAIT=16 cycles with mem_err pulse.
//  Drop reset_n while mem_req=1 -> mem_req=0 immediately, in_ready=1 after release, late ack ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage running a req/ack data-memory handshake and producing one writeback record per instruction.
module mem_access_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_rt_data,
    input  logic [4:0]  in_dest_reg,
    input  logic        in_reg_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dest,
    output logic        wb_reg_write,
    output logic [31:0] wb_pc,
    output logic        mem_err
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_next;
    logic [CW-1:0] wait_cnt;
    logic [5:0] op;
    logic is_lw, is_sw, is_lb, is_lbu, is_sb, is_mem, is_store, misaligned, accept, timeout;
    logic p_lw, p_lb, p_lbu, p_store, p_reg_write;
    logic [1:0] p_lane;
    logic [4:0] p_dest;
    logic [31:0] p_pc, load_data;
    logic [7:0] sel_byte;
    logic unused_insn_bits;
    assign op = in_insn[31:26];
    assign unused_insn_bits = ^in_insn[25:0];
    assign is_lw = op == 6'b100011;
    assign is_sw = op == 6'b101011;
    assign is_lb = op == 6'b100000;
    assign is_lbu = op == 6'b100100;
    assign is_sb = op == 6'b101000;
    assign is_mem = is_lw | is_sw | is_lb | is_lbu | is_sb;
    assign is_store = is_sw | is_sb;
    assign misaligned = (is_lw | is_sw) & (|in_alu_result[1:0]);
    assign in_ready = state == IDLE;
    assign accept = in_valid & in_ready;
    assign timeout = wait_cnt == CW'(MAX_WAIT - 1);
    // Lane 0 is the most significant byte (big-endian).
    assign sel_byte = mem_rdata[{~p_lane, 3'b000} +: 8];
    assign load_data = p_lw ? mem_rdata :
                       p_lb ? {{24{sel_byte[7]}}, sel_byte} :
                       p_lbu ? {24'h0, sel_byte} : 32'h0;
    always_comb begin
        state_next = state;
        state_next = (state == IDLE) ? ((accept && is_mem && !misaligned) ? ACCESS : IDLE)
                                     : ((mem_ack || timeout) ? IDLE : ACCESS);
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_next;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_be <= '0;
            wb_valid <= 1'b0;
            wb_data <= '0;
            wb_dest <= '0;
            wb_reg_write <= 1'b0;
            wb_pc <= '0;
            mem_err <= 1'b0;
            p_lw <= 1'b0;
            p_lb <= 1'b0;
            p_lbu <= 1'b0;
            p_store <= 1'b0;
            p_reg_write <= 1'b0;
            p_lane <= '0;
            p_dest <= '0;
            p_pc <= '0;
        end else begin
            wb_valid <= 1'b0;
            mem_err <= 1'b0;
            if (state == IDLE) begin
                if (accept && (!is_mem || misaligned)) begin
                    wb_valid <= 1'b1;
                    mem_err <= misaligned;
                    wb_data <= in_alu_result;
                    wb_dest <= in_dest_reg;
                    wb_pc <= in_pc;
                    wb_reg_write <= in_reg_write && in_dest_reg != 5'd0 && !misaligned;
                end else if (accept) begin
                    mem_req <= 1'b1;
                    mem_we <= is_store;
                    mem_addr <= {in_alu_result[31:2], 2'b00};
                    mem_wdata <= is_sb ? {4{in_rt_data[7:0]}} : in_rt_data;
                    mem_be <= (is_lw | is_sw) ? 4'b1111 : 4'b1000 >> in_alu_result[1:0];
                    wait_cnt <= '0;
                    p_lw <= is_lw;
                    p_lb <= is_lb;
                    p_lbu <= is_lbu;
                    p_store <= is_store;
                    p_reg_write <= in_reg_write;
                    p_lane <= in_alu_result[1:0];
                    p_dest <= in_dest_reg;
                    p_pc <= in_pc;
                end
            end else if (mem_ack || timeout) begin
                mem_req <= 1'b0;
                wb_valid <= 1'b1;
                mem_err <= !mem_ack;
                wb_data <= mem_ack ? load_data : 32'h0;
                wb_dest <= p_dest;
                wb_pc <= p_pc;
                wb_reg_write <= mem_ack && p_reg_write && p_dest != 5'd0 && !p_store;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized and directed checks of mem_access_stage against a transaction-level model.
module tb_mem_access_stage;
    localparam int MAX_WAIT = 16;
    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, LB = 6'h20, LBU = 6'h24, SB = 6'h28;
    logic clock = 1'b0, reset_n = 1'b0;
    logic in_valid = 1'b0, in_ready, in_reg_write = 1'b0;
    logic [31:0] in_insn = '0, in_pc = '0, in_alu_result = '0, in_rt_data = '0;
    logic [4:0] in_dest_reg = '0;
    logic mem_req, mem_we, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0] mem_be;
    logic wb_valid, wb_reg_write, mem_err;
    logic [31:0] wb_data, wb_pc;
    logic [4:0] wb_dest;
    int checks = 0, failures = 0;
    bit busy;
    int waited, plan;
    logic exp_req, exp_we, exp_wb_valid, exp_err, exp_rw;
    logic [31:0] exp_addr, exp_wdata, exp_data, exp_pc;
    logic [3:0] exp_be;
    logic [4:0] exp_dest;
    logic [5:0] p_op;
    logic [31:0] p_addr, p_pc;
    logic [4:0] p_dest;
    logic p_rw;

    mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_insn(in_insn), .in_pc(in_pc), .in_alu_result(in_alu_result), .in_rt_data(in_rt_data),
        .in_dest_reg(in_dest_reg), .in_reg_write(in_reg_write), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest),
        .wb_reg_write(wb_reg_write), .wb_pc(wb_pc), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        busy = 0; waited = 0; plan = 0;
        exp_req = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_be = 0;
        exp_wb_valid = 0; exp_err = 0; exp_rw = 0; exp_data = 0; exp_pc = 0; exp_dest = 0;
    endtask

    // Predicts the outputs after the coming edge from the current inputs.
    task automatic model_step();
        logic [5:0] op;
        logic [7:0] b;
        bit word;
        op = in_insn[31:26];
        exp_wb_valid = 0;
        exp_err = 0;
        if (busy) begin
            if (mem_ack) begin
                b = 8'(mem_rdata >> (8 * (3 - int'(p_addr % 4))));
                exp_data = p_op == LW ? mem_rdata : p_op == LB ? {{24{b[7]}}, b} :
                           p_op == LBU ? {24'h0, b} : 32'h0;
                exp_rw = p_rw && p_dest != 0 && p_op != SW && p_op != SB;
                exp_wb_valid = 1; exp_dest = p_dest; exp_pc = p_pc; busy = 0; exp_req = 0;
            end else begin
                waited++;
                if (waited == MAX_WAIT) begin
                    exp_wb_valid = 1; exp_err = 1; exp_rw = 0; exp_dest = p_dest; exp_pc = p_pc;
                    busy = 0; exp_req = 0;
                end
            end
        end else if (in_valid) begin
            word = op == LW || op == SW;
            if (!(op inside {LW, SW, LB, LBU, SB})) begin
                exp_wb_valid = 1; exp_data = in_alu_result; exp_dest = in_dest_reg; exp_pc = in_pc;
                exp_rw = in_reg_write && in_dest_reg != 0;
            end else if (word && in_alu_result % 4 != 0) begin
                exp_wb_valid = 1; exp_err = 1; exp_rw = 0; exp_dest = in_dest_reg; exp_pc = in_pc;
            end else begin
                busy = 1; waited = 0; exp_req = 1;
                exp_we = op == SW || op == SB;
                exp_addr = in_alu_result - in_alu_result % 4;
                exp_be = word ? 4'hF : 4'(8 >> (in_alu_result % 4));
                exp_wdata = op == SB ? {4{in_rt_data[7:0]}} : in_rt_data;
                p_op = op; p_addr = in_alu_result; p_dest = in_dest_reg; p_rw = in_reg_write; p_pc = in_pc;
                plan = ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, 5));
            end
        end
    endtask

    task automatic compare();
        chk("in_ready", in_ready, !busy);
        chk("mem_req", mem_req, exp_req);
        chk("wb_valid", wb_valid, exp_wb_valid);
        chk("mem_err", mem_err, exp_err);
        if (exp_req) begin
            chk("mem_we", mem_we, exp_we);
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_be", mem_be, exp_be);
            if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
        end
        if (exp_wb_valid) begin
            chk("wb_dest", wb_dest, exp_dest);
            chk("wb_pc", wb_pc, exp_pc);
            chk("wb_reg_write", wb_reg_write, exp_rw);
            if (!exp_err) chk("wb_data", wb_data, exp_data);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
        compare();
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] rt,
                         input logic [4:0] dest, input logic rw);
        in_valid = 1; in_insn = {op, 26'($urandom)}; in_alu_result = alu; in_rt_data = rt;
        in_dest_reg = dest; in_reg_write = rw; in_pc = $urandom & ~32'h3;
    endtask

    task automatic do_mem(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] rt,
                          input int delay, input logic [31:0] rdata, output int hi,
                          output logic [3:0] be, output logic [31:0] wd, output logic we);
        drive(op, alu, rt, 5'd9, 1'b1);
        mem_ack = 0;
        tick();
        be = mem_be; wd = mem_wdata; we = mem_we;
        in_valid = 0; hi = 0;
        for (int n = 0; n < 40 && !wb_valid; n++) begin
            if (mem_req) hi++;
            if (!in_ready) chk("busy_ready", in_ready, 1'b0);
            mem_ack = delay != 0 && n + 1 == delay;
            mem_rdata = rdata;
            tick();
        end
        mem_ack = 0;
        chk("retired", wb_valid, 1'b1);
    endtask

    initial begin
        int hi;
        logic [3:0] be;
        logic [31:0] wd;
        logic we;
        logic [5:0] op;
        logic [31:0] a;
        model_reset();
        repeat (2) @(negedge clock);
        compare();
        chk("reset_req", mem_req, 1'b0);
        chk("reset_wbv", wb_valid, 1'b0);
        chk("reset_ready", in_ready, 1'b1);
        reset_n = 1;

        drive(6'h00, 32'h1234, 32'h0, 5'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("addu_wbv", wb_valid, 1'b1);
            chk("addu_data", wb_data, 32'h1234);
            chk("addu_rw", wb_reg_write, 1'b1);
        end
        in_valid = 0;
        tick();

        do_mem(LW, 32'h100, 32'h0, 3, 32'hDEADBEEF, hi, be, wd, we);
        chk("lw_req_cycles", hi, 3);
        chk("lw_be", be, 4'hF);
        chk("lw_data", wb_data, 32'hDEADBEEF);

        do_mem(LB, 32'h101, 32'h0, 2, 32'h11F02233, hi, be, wd, we);
        chk("lb_be", be, 4'b0100);
        chk("lb_data", wb_data, 32'hFFFFFFF0);
        chk("model_lb", exp_data, 32'hFFFFFFF0);

        do_mem(LBU, 32'h101, 32'h0, 1, 32'h11F02233, hi, be, wd, we);
        chk("lbu_data", wb_data, 32'h000000F0);
        chk("model_lbu", exp_data, 32'h000000F0);

        do_mem(SB, 32'h203, 32'hAB, 2, 32'h0, hi, be, wd, we);
        chk("sb_be", be, 4'b0001);
        chk("sb_wdata", wd, 32'hABABABAB);
        chk("sb_we", we, 1'b1);
        chk("sb_rw", wb_reg_write, 1'b0);

        drive(LW, 32'h102, 32'h0, 5'd7, 1'b1);
        tick();
        in_valid = 0;
        chk("mis_req", mem_req, 1'b0);
        chk("mis_err", mem_err, 1'b1);
        chk("mis_rw", wb_reg_write, 1'b0);
        tick();
        chk("mis_err_pulse", mem_err, 1'b0);

        do_mem(LW, 32'h400, 32'h0, 0, 32'h0, hi, be, wd, we);
        chk("to_req_cycles", hi, MAX_WAIT);
        chk("to_err", mem_err, 1'b1);
        chk("to_rw", wb_reg_write, 1'b0);

        drive(LW, 32'h300, 32'h0, 5'd3, 1'b1);
        tick();
        in_valid = 0;
        tick();
        chk("pre_rst_req", mem_req, 1'b1);
        #2 reset_n = 0;
        #1;
        chk("rst_req_drop", mem_req, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        model_reset();
        @(negedge clock);
        reset_n = 1;
        mem_ack = 1;
        mem_rdata = 32'h55AA55AA;
        tick();
        chk("late_ack_wbv", wb_valid, 1'b0);
        mem_ack = 0;

        for (int c = 0; c < 3000; c++) begin
            op = 6'($urandom);
            case ($urandom % 8)
                0: op = LW;
                1: op = SW;
                2: op = LB;
                3: op = LBU;
                4: op = SB;
                default: if (op inside {LW, SW, LB, LBU, SB}) op = 6'h00;
            endcase
            a = $urandom;
            if ((op == LW || op == SW) && $urandom % 4 != 0) a[1:0] = 2'b00;
            drive(op, a, $urandom, 5'($urandom), 1'($urandom));
            in_valid = busy ? 1'($urandom) : ($urandom % 3 != 0);
            mem_ack = busy ? (plan != 0 && waited + 1 == plan) : ($urandom % 6 == 0);
            mem_rdata = $urandom;
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
